vram_fill: RTL and testbench
============================

# vram_fill

Rectangle-fill engine on the write side of the video RAM. It accepts a fill command (origin, size, colour) from the CPU/MMIO side and streams word writes into the 160×120, 8-bit-per-pixel framebuffer that the VGA scanout reads. One write per cycle, no read-modify-write: partial words use a byte mask.

## Interface
Parameters:
- `FB_W`, 160: framebuffer width in pixels.
- `FB_H`, 120: framebuffer height in lines.
- `WORDS_PER_LINE`, 80: VRAM words per line (FB_W/2).

Ports:
- `clk` in 1: the single clock for the block.
- `resetn` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: a command is present.
- `cmd_ready` out 1: engine idle, can accept a command.
- `cmd_x` in 8: left pixel column.
- `cmd_y` in 7: top line.
- `cmd_w` in 8: width in pixels.
- `cmd_h` in 7: height in lines.
- `cmd_color` in 8: pixel value (RGB222 in bits 5:0; bits 7:6 written as given).
- `vram_we` out 1: write strobe.
- `vram_waddr` out 14: word address.
- `vram_wdata` out 16: `{cmd_color, cmd_color}`.
- `vram_wmask` out 2: bit1 = bits 15:8 (even pixel), bit0 = bits 7:0 (odd pixel).
- `busy` out 1: a command is in progress.
- `done` out 1: one-cycle pulse when a command completes.

## Operation
- Pixel (x,y) is at word `80*y + x[7:1]`. Even x uses the upper byte, odd x the lower byte.
- Handshake: a command is accepted on a rising edge with `cmd_valid && cmd_ready`. All `cmd_*` values are latched at that edge. `cmd_ready = !busy`.
- Clipping is done at accept time:
  - If `x>=160`, `y>=120`, `w==0` or `h==0`, the rectangle is empty.
  - Otherwise `w_eff = min(w, 160-x)` and `h_eff = min(h, 120-y)`. Use 9-bit sums for `x+w`.
- Per row, with `xl=x` and `xr=x+w_eff-1`, words run from `xl>>1` to `xr>>1`. Masks:
  - Single-word row: mask = `{!xl[0], xr[0]}`.
  - First word of a multi-word row: `xl[0] ? 01 : 11`.
  - Last word: `xr[0] ? 11 : 10`.
  - Middle words: `11`.
- The row base starts at `80*y` and is advanced by +80 per row. No multiplier is used in the loop.
- States:
  - IDLE: `cmd_ready=1`. On accept, go to FILL, or to DONE if the rectangle is empty.
  - FILL: one write per cycle. At the end of a row, wrap to the next row. After the last word of the last row, go to DONE.
  - DONE: `done=1` for one cycle, then IDLE.
- A command presented while busy is not accepted. It is held off by `cmd_ready=0`.
- There is no VRAM backpressure: the write port is dedicated and always accepts.

## Timing
- Reset values: `cmd_ready=1`, `busy=0`, `done=0`, `vram_we=0`, `vram_waddr=0`, `vram_wdata=0`, `vram_wmask=0`, state IDLE.
- All VRAM outputs are registered.
- First `vram_we` is in the cycle after the accept edge. Writes are back-to-back, with no gap between rows.
- `done` is asserted in the cycle after the last write. `busy` is high from the cycle after accept through the `done` cycle.
- `cmd_ready` returns to 1 in the cycle after `done`.
- An empty command gives `done` in the cycle after accept, with zero writes.
- Total write cycles = `h_eff × words_per_row`.
- `resetn` low mid-command: all outputs drop to reset values immediately (asynchronously). The command is abandoned; no `done` is generated.
- Maximum address is 9599, which fits in 14 bits. No address wraps.

## Structure
- Shared package `video_pkg` holds `FB_W`, `FB_H`, `WORDS_PER_LINE`, the pixel width (8), and the state enum (IDLE/FILL/DONE). The scanout uses the same geometry constants.
- One sub-module is natural: `vram_span_calc`, a combinational block. From `x`, `w_eff` it produces the first word, last word and their masks.
- The FSM, row counter and address counters stay in `vram_fill`.

## Test plan
- Single even pixel `x=4,y=0,w=1,h=1,color=0x2A` -> one write: addr 2, data 0x2A2A, mask 10. `done` follows one cycle later.
- Odd start `x=3,y=1,w=4,h=1,color=0x15` -> three consecutive writes:
  - addr 81 mask 01
  - addr 82 mask 11
  - addr 83 mask 10
- Clip `x=158,y=119,w=10,h=5` -> exactly one write: addr 9599, mask 11.
- Empty commands `w=0`, `h=0`, and `x=200` -> zero writes; `done` one cycle after accept.
- Full screen `x=0,y=0,w=160,h=120` -> 9600 contiguous writes at addr 0..9599, all mask 11. `cmd_valid` held during the run is not accepted until `cmd_ready` returns.
- `resetn` pulsed low after 10 writes of a 2-row fill -> `vram_we=0` immediately and no `done`. A new command after release starts cleanly at its own base address.

Source files
------------

// File: rtl/video_pkg.sv
// Framebuffer geometry and fill-engine state encoding shared by the VRAM
// write side (vram_fill) and the VGA scanout.
package video_pkg;
    localparam int unsigned FB_W           = 160;
    localparam int unsigned FB_H           = 120;
    localparam int unsigned WORDS_PER_LINE = 80;
    localparam int unsigned PIX_W          = 8;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } fill_state_t;
endpackage

// File: rtl/vram_fill_if.sv
// Fill-command handshake plus the dedicated VRAM write port of vram_fill.
interface vram_fill_if;
    import video_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_x;
    logic [6:0]       cmd_y;
    logic [7:0]       cmd_w;
    logic [6:0]       cmd_h;
    logic [PIX_W-1:0] cmd_color;
    logic             vram_we;
    logic [13:0]      vram_waddr;
    logic [15:0]      vram_wdata;
    logic [1:0]       vram_wmask;
    logic             busy;
    logic             done;

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        output cmd_ready, vram_we, vram_waddr, vram_wdata, vram_wmask, busy, done
    );

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        input  cmd_ready, vram_we, vram_waddr, vram_wdata, vram_wmask, busy, done
    );
endinterface

// File: rtl/vram_span_calc.sv
// Word span of one clipped row: first/last VRAM word and their byte masks.
// Inputs must already be clipped (w_eff >= 1, x + w_eff <= FB_W).
module vram_span_calc (
    input  logic [7:0] x,
    input  logic [7:0] w_eff,
    output logic [6:0] first_word,
    output logic [6:0] last_word,
    output logic [1:0] first_mask,
    output logic [1:0] last_mask
);
    logic [7:0] xr;

    always_comb begin
        xr         = x + w_eff - 8'd1;
        first_word = x[7:1];
        last_word  = xr[7:1];
        // Mask bit1 is the even (upper-byte) pixel, bit0 the odd one.
        if (first_word == last_word) begin
            first_mask = {~x[0], xr[0]};
        end else begin
            first_mask = x[0] ? 2'b01 : 2'b11;
        end
        last_mask = xr[0] ? 2'b11 : 2'b10;
    end
endmodule

// File: rtl/vram_fill.sv
// Rectangle-fill engine: clips a fill command on accept, then streams one
// masked VRAM word write per cycle, row after row, with no gaps.
module vram_fill
    import video_pkg::*;
#(
    parameter int unsigned FB_W           = video_pkg::FB_W,
    parameter int unsigned FB_H           = video_pkg::FB_H,
    parameter int unsigned WORDS_PER_LINE = video_pkg::WORDS_PER_LINE
) (
    input  logic        clk,
    input  logic        resetn,
    vram_fill_if.slave  bus
);
    localparam logic [7:0]  X_LIM = 8'(FB_W);
    localparam logic [6:0]  Y_LIM = 7'(FB_H);
    localparam logic [13:0] STEP  = 14'(WORDS_PER_LINE);

    fill_state_t state;
    logic        busy, cmd_ready, done;
    logic        vram_we;
    logic [13:0] vram_waddr;
    logic [15:0] vram_wdata;
    logic [1:0]  vram_wmask;
    logic [13:0] row_base;
    logic [6:0]  col, first_word, last_word, rows_left;
    logic [1:0]  first_mask, last_mask;

    logic        empty;
    logic [8:0]  x_end;
    logic [7:0]  y_end;
    logic [7:0]  w_eff;
    logic [6:0]  h_eff;
    logic [13:0] base0;
    logic [6:0]  sp_first, sp_last;
    logic [1:0]  sp_first_mask, sp_last_mask;

    always_comb begin
        x_end = {1'b0, bus.cmd_x} + {1'b0, bus.cmd_w};
        y_end = {1'b0, bus.cmd_y} + {1'b0, bus.cmd_h};
        empty = (bus.cmd_x >= X_LIM) || (bus.cmd_y >= Y_LIM) ||
                (bus.cmd_w == 8'd0) || (bus.cmd_h == 7'd0);
        w_eff = (x_end > 9'(FB_W)) ? (X_LIM - bus.cmd_x) : bus.cmd_w;
        h_eff = (y_end > 8'(FB_H)) ? (Y_LIM - bus.cmd_y) : bus.cmd_h;
        base0 = 14'(bus.cmd_y * WORDS_PER_LINE);
    end

    vram_span_calc u_span (
        .x          (bus.cmd_x),
        .w_eff      (w_eff),
        .first_word (sp_first),
        .last_word  (sp_last),
        .first_mask (sp_first_mask),
        .last_mask  (sp_last_mask)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            busy       <= 1'b0;
            cmd_ready  <= 1'b1;
            done       <= 1'b0;
            vram_we    <= 1'b0;
            vram_waddr <= '0;
            vram_wdata <= '0;
            vram_wmask <= '0;
            row_base   <= '0;
            col        <= '0;
            first_word <= '0;
            last_word  <= '0;
            first_mask <= '0;
            last_mask  <= '0;
            rows_left  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready) begin
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        if (empty) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            // The first write is issued straight from the accept edge.
                            state      <= FILL;
                            vram_we    <= 1'b1;
                            vram_waddr <= base0 + {7'b0, sp_first};
                            vram_wdata <= {bus.cmd_color, bus.cmd_color};
                            vram_wmask <= sp_first_mask;
                            row_base   <= base0;
                            col        <= sp_first;
                            first_word <= sp_first;
                            last_word  <= sp_last;
                            first_mask <= sp_first_mask;
                            last_mask  <= sp_last_mask;
                            rows_left  <= h_eff;
                        end
                    end
                end
                FILL: begin
                    if (col != last_word) begin
                        col        <= col + 7'd1;
                        vram_waddr <= vram_waddr + 14'd1;
                        vram_wmask <= (col + 7'd1 == last_word) ? last_mask : 2'b11;
                    end else if (rows_left != 7'd1) begin
                        rows_left  <= rows_left - 7'd1;
                        row_base   <= row_base + STEP;
                        col        <= first_word;
                        vram_waddr <= row_base + STEP + {7'b0, first_word};
                        vram_wmask <= first_mask;
                    end else begin
                        vram_we <= 1'b0;
                        state   <= DONE;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.vram_we    = vram_we;
    assign bus.vram_waddr = vram_waddr;
    assign bus.vram_wdata = vram_wdata;
    assign bus.vram_wmask = vram_wmask;
endmodule

// File: tb/tb_vram_fill.sv
// Bench for vram_fill: directed and random fill commands checked against a
// pixel-level reference model of the framebuffer writes.
module tb_vram_fill;
    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    vram_fill_if bus();

    vram_fill #(
        .FB_W           (160),
        .FB_H           (120),
        .WORDS_PER_LINE (80)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    typedef struct packed {
        logic [13:0] addr;
        logic [15:0] data;
        logic [1:0]  mask;
    } wr_t;

    wr_t         obs[$];
    wr_t         exp_q[$];
    int unsigned done_cnt = 0;
    int          total = 0;
    int          bad   = 0;

    always @(negedge clk) begin
        if (resetn) begin
            if (bus.vram_we) obs.push_back('{bus.vram_waddr, bus.vram_wdata, bus.vram_wmask});
            if (bus.done) done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    // Reference: walk every covered pixel, merging neighbours that share a word.
    task automatic build_exp(input int x, input int y, input int w, input int h, input int c);
        int    xe, ye, start;
        int    addr;
        logic [1:0]  m;
        logic [15:0] d;
        xe    = (x + w > 160) ? 160 : x + w;
        ye    = (y + h > 120) ? 120 : y + h;
        start = exp_q.size();
        d     = {8'(c), 8'(c)};
        if (x < 160 && y < 120) begin
            for (int yy = y; yy < ye; yy++) begin
                for (int xx = x; xx < xe; xx++) begin
                    addr = 80 * yy + xx / 2;
                    m    = (xx % 2 == 0) ? 2'b10 : 2'b01;
                    if (exp_q.size() > start && int'(exp_q[exp_q.size()-1].addr) == addr)
                        exp_q[exp_q.size()-1].mask = exp_q[exp_q.size()-1].mask | m;
                    else
                        exp_q.push_back('{14'(addr), d, m});
                end
            end
        end
    endtask

    task automatic drive_cmd(input int x, input int y, input int w, input int h, input int c,
                             input bit hold);
        int n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_x     = 8'(x);
        bus.cmd_y     = 7'(y);
        bus.cmd_w     = 8'(w);
        bus.cmd_h     = 7'(h);
        bus.cmd_color = 8'(c);
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int nexp);
        int lat  = 0;
        bit seen = 1'b0;
        while (!seen && lat < 12000) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
                chk({tag, "_rdy0"}, 64'(bus.cmd_ready), 64'd0);
            end
            seen = bus.done;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(nexp + 1));
        @(negedge clk);
        chk({tag, "_post"}, {61'b0, bus.done, bus.busy, bus.cmd_ready}, 64'b001);
    endtask

    task automatic compare_writes(input string tag);
        chk({tag, "_nwr"}, 64'(obs.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), 64'(obs[i]), 64'(exp_q[i]));
    endtask

    task automatic run(input string tag, input int x, input int y, input int w, input int h,
                       input int c);
        obs.delete();
        exp_q.delete();
        build_exp(x, y, w, h, c);
        drive_cmd(x, y, w, h, c, 1'b0);
        wait_done(tag, exp_q.size());
        compare_writes(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ctl"}, {60'b0, bus.cmd_ready, bus.busy, bus.done, bus.vram_we}, 64'b1000);
        chk({tag, "_addr"}, 64'(bus.vram_waddr), 64'd0);
        chk({tag, "_data"}, 64'(bus.vram_wdata), 64'd0);
        chk({tag, "_mask"}, 64'(bus.vram_wmask), 64'd0);
    endtask

    initial begin
        int d0, n, k;
        int x, y, w, h, c;
        bus.cmd_valid = 1'b0;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_w     = '0;
        bus.cmd_h     = '0;
        bus.cmd_color = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        resetn = 1'b1;

        run("even1", 4, 0, 1, 1, 8'h2A);
        chk("even1_const", 64'(obs.size() > 0 ? obs[0] : '0), 64'({14'd2, 16'h2A2A, 2'b10}));
        run("odd3", 3, 1, 4, 1, 8'h15);
        run("clip", 158, 119, 10, 5, 8'hC3);
        chk("clip_const", 64'(obs.size() > 0 ? obs[0] : '0), 64'({14'd9599, 16'hC3C3, 2'b11}));
        run("w0", 10, 10, 0, 5, 8'h11);
        run("h0", 10, 10, 5, 0, 8'h22);
        run("x200", 200, 10, 5, 5, 8'h33);
        run("y120", 0, 120, 4, 4, 8'h44);
        run("single_odd", 7, 3, 1, 3, 8'hE1);

        // Full screen with a second command held on cmd_valid throughout.
        obs.delete();
        exp_q.delete();
        build_exp(0, 0, 160, 120, 8'h3F);
        drive_cmd(0, 0, 160, 120, 8'h3F, 1'b1);
        bus.cmd_x     = 8'd5;
        bus.cmd_y     = 7'd7;
        bus.cmd_w     = 8'd3;
        bus.cmd_h     = 7'd2;
        bus.cmd_color = 8'h21;
        wait_done("full", exp_q.size());
        compare_writes("full");
        obs.delete();
        exp_q.delete();
        build_exp(5, 7, 3, 2, 8'h21);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        wait_done("held", exp_q.size());
        compare_writes("held");

        // Reset in the middle of a two-row fill.
        obs.delete();
        exp_q.delete();
        build_exp(0, 10, 160, 2, 8'h0F);
        d0 = int'(done_cnt);
        drive_cmd(0, 10, 160, 2, 8'h0F, 1'b0);
        n = 0;
        k = 0;
        while (n < 10 && k < 100) begin
            @(negedge clk);
            k++;
            if (bus.vram_we) n++;
        end
        #2 resetn = 1'b0;
        #1 check_reset_vals("midrst");
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_done", 64'(int'(done_cnt) - d0), 64'd0);
        chk("midrst_nwr", 64'(obs.size()), 64'd10);
        for (int i = 0; i < 10 && i < obs.size(); i++)
            chk($sformatf("midrst_wr%0d", i), 64'(obs[i]), 64'(exp_q[i]));
        run("after_rst", 6, 20, 5, 3, 8'h33);

        for (int i = 0; i < 24; i++) begin
            x = int'($urandom_range(0, 199));
            y = int'($urandom_range(0, 127));
            w = ($urandom % 4 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
            h = ($urandom % 4 == 0) ? int'($urandom_range(0, 24)) : int'($urandom_range(0, 6));
            c = int'($urandom_range(0, 255));
            run($sformatf("rnd%0d", i), x, y, w, h, c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
